// File: rtl/data_unfifo_blk.sv
// ---------------------------------------------------------------------------
// data_unfifo_blk
//
// Single-lane inverse-reorder buffer for the 64-point FFT datapath.
// A 16-word frame is written one word per cycle. Word k goes to address
// (k + WR_OFFSET) mod 16. When the frame is complete, it is read back
// linearly from address 0 to 15. Two banks are used in ping-pong fashion,
// so back-to-back frames stream out with no gap cycles.
//
// Parameters:
//   WIDTH      data word width in bits
//   WR_OFFSET  write-address rotation, 0..15
//
// Ports:
//   clk         clock; all logic on the rising edge
//   rst         asynchronous, active-low reset
//   data_in     input word, taken every cycle while a frame is filling
//   ctrl_in     one-cycle start marker, coincident with word 0
//   data_out    registered output word; holds when data_valid is low
//   ctrl_out    one-cycle marker on the output word from read address 0
//   data_valid  high for the 16 cycles that carry a frame
//   addr        write address used this cycle
//   frame_err   one-cycle pulse after a restarted partial frame
//
// Optional feature macro: DATA_UNFIFO_FRAME_ERR_EN
//   When defined, restart detection drives frame_err.
//   When undefined, frame_err is tied low and no detection logic is built.
// ---------------------------------------------------------------------------
module data_unfifo_blk #(
    parameter int WIDTH     = 32,
    parameter int WR_OFFSET = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ctrl_in,
    output logic [WIDTH-1:0] data_out,
    output logic             ctrl_out,
    output logic             data_valid,
    output logic [3:0]       addr,
    output logic             frame_err
);

    localparam logic [3:0] OFFSET = 4'(WR_OFFSET);

    typedef enum logic {W_IDLE, W_FILL} wr_state_e;
    typedef enum logic {R_IDLE, R_RUN}  rd_state_e;

    wr_state_e        wrState_q, wrState_d;
    logic [3:0]       wrCnt_q, wrCnt_d;
    logic             wb_q, wb_d;

    rd_state_e        rdState_q, rdState_d;
    logic [3:0]       rdCnt_q, rdCnt_d;
    logic             rb_q, rb_d;

    logic [WIDTH-1:0] dataOut_q;
    logic             ctrlOut_q;
    logic             validOut_q;

    logic             wrEn;
    logic [3:0]       wrIdx;
    logic             bankReady;
    logic             rdEn;

    // Bank is the MSB of the index: {bank, address}.
    logic [WIDTH-1:0] mem [32];

    // Write FSM. wrIdx is the frame word index written this cycle.
    // A restart rewrites word 0 into the same bank and raises no bank-ready.
    always_comb begin
        wrState_d = wrState_q;
        wrCnt_d   = wrCnt_q;
        wb_d      = wb_q;
        wrEn      = 1'b0;
        wrIdx     = 4'd0;
        bankReady = 1'b0;
        case (wrState_q)
            W_IDLE: begin
                wrCnt_d = 4'd0;
                if (ctrl_in) begin
                    wrEn      = 1'b1;
                    wrCnt_d   = 4'd1;
                    wrState_d = W_FILL;
                end
            end
            W_FILL: begin
                wrEn = 1'b1;
                if (wrCnt_q == 4'd15) begin
                    // Last word completes the frame. Hand the bank to the
                    // reader. A coincident ctrl_in keeps filling the new bank.
                    wrIdx     = 4'd15;
                    bankReady = 1'b1;
                    wb_d      = ~wb_q;
                    wrCnt_d   = 4'd0;
                    wrState_d = ctrl_in ? W_FILL : W_IDLE;
                end else if (ctrl_in && (wrCnt_q != 4'd0)) begin
                    wrIdx   = 4'd0;
                    wrCnt_d = 4'd1;
                end else begin
                    wrIdx   = wrCnt_q;
                    wrCnt_d = wrCnt_q + 4'd1;
                end
            end
            default: wrState_d = W_IDLE;
        endcase
    end

    assign addr = wrIdx + OFFSET;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[{wb_q, addr}] <= data_in;
        end
    end

    // Read FSM. It latches the bank that has just been completed. Because
    // fill and drain both take 16 cycles, the reader never overlaps a rewrite.
    always_comb begin
        rdState_d = rdState_q;
        rdCnt_d   = rdCnt_q;
        rb_d      = rb_q;
        rdEn      = 1'b0;
        case (rdState_q)
            R_IDLE: begin
                if (bankReady) begin
                    rdState_d = R_RUN;
                    rdCnt_d   = 4'd0;
                    rb_d      = wb_q;
                end
            end
            R_RUN: begin
                rdEn = 1'b1;
                if (rdCnt_q == 4'd15) begin
                    rdCnt_d = 4'd0;
                    if (bankReady) begin
                        rb_d = wb_q;
                    end else begin
                        rdState_d = R_IDLE;
                    end
                end else begin
                    rdCnt_d = rdCnt_q + 4'd1;
                end
            end
            default: rdState_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrState_q  <= W_IDLE;
            wrCnt_q    <= 4'd0;
            wb_q       <= 1'b0;
            rdState_q  <= R_IDLE;
            rdCnt_q    <= 4'd0;
            rb_q       <= 1'b0;
            dataOut_q  <= '0;
            ctrlOut_q  <= 1'b0;
            validOut_q <= 1'b0;
        end else begin
            wrState_q  <= wrState_d;
            wrCnt_q    <= wrCnt_d;
            wb_q       <= wb_d;
            rdState_q  <= rdState_d;
            rdCnt_q    <= rdCnt_d;
            rb_q       <= rb_d;
            if (rdEn) begin
                dataOut_q <= mem[{rb_q, rdCnt_q}];
            end
            ctrlOut_q  <= rdEn && (rdCnt_q == 4'd0);
            validOut_q <= rdEn;
        end
    end

    assign data_out   = dataOut_q;
    assign ctrl_out   = ctrlOut_q;
    assign data_valid = validOut_q;

`ifdef DATA_UNFIFO_FRAME_ERR_EN
    // A restart is ctrl_in in the middle of a fill. A ctrl_in on the
    // completing word is a back-to-back start, not a restart.
    logic restartHit;
    logic frameErr_q;

    assign restartHit = (wrState_q == W_FILL) && ctrl_in &&
                        (wrCnt_q != 4'd0) && (wrCnt_q != 4'd15);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frameErr_q <= 1'b0;
        end else begin
            frameErr_q <= restartHit;
        end
    end

    assign frame_err = frameErr_q;
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_unfifo_blk.sv
// Testbench for data_unfifo_blk. Five instances share the same input stream,
// with WR_OFFSET values 0, 4, 8, 12 and 15. A frame-level model predicts
// every output on every cycle.
module tb_data_unfifo_blk;

   localparam int NI = 5;
   localparam int NC = 4096;

   logic        clk;
   logic        rst;
   logic [31:0] dataIn;
   logic        ctrlIn;
   logic [31:0] dOut [NI];
   logic        cOut [NI];
   logic        vOut [NI];
   logic        eOut [NI];
   logic [3:0]  aOut [NI];

   function automatic int offOf(input int g);
      return (g == 4) ? 15 : g * 4;
   endfunction

   // One DUT per lane offset, all fed the same input stream.
   for (genvar g = 0; g < NI; g++) begin : gInst
      data_unfifo_blk #(.WIDTH(32), .WR_OFFSET((g == 4) ? 15 : g * 4)) dut (
         .clk(clk), .rst(rst), .data_in(dataIn), .ctrl_in(ctrlIn),
         .data_out(dOut[g]), .ctrl_out(cOut[g]), .data_valid(vOut[g]),
         .addr(aOut[g]), .frame_err(eOut[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: frame-level view with a per-cycle output schedule.
   int          nChecks;
   int          nFail;
   int          cyc;
   bit          expV [NC];
   bit          expC [NC];
   bit          expE [NC];
   logic [31:0] expD [NI][NC];
   logic [31:0] lastD [NI];
   logic [31:0] fillQ [$];
   bit          filling;

   logic [31:0] obsD [NI];
   logic        obsV [NI];
   logic        obsC [NI];
   logic        obsE [NI];
   logic [3:0]  obsA [NI];

   typedef struct {
      bit          ctrlIn;
      logic [31:0] dataIn;
      bit          expValid;
      bit          expCtrl;
      logic [31:0] expData;
      logic [3:0]  expAddr;
   } vec_t;

   vec_t tbl [36];

   // Compare a value and record a failure with both values.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Drive one cycle of input, check every output against the model,
   // then advance the model by that cycle.
   task automatic applyStimulus(input bit ctrl, input logic [31:0] data);
      int ea;
      @(negedge clk);
      ctrlIn = ctrl;
      dataIn = data;
      #1;
      for (int g = 0; g < NI; g++) begin
         if (expV[cyc]) lastD[g] = expD[g][cyc];
         ea = (ctrl || !filling) ? offOf(g) : (fillQ.size() + offOf(g)) % 16;
         checkOutput($sformatf("data_out[%0d]", g), dOut[g], lastD[g]);
         checkOutput($sformatf("data_valid[%0d]", g), 32'(vOut[g]), 32'(expV[cyc]));
         checkOutput($sformatf("ctrl_out[%0d]", g), 32'(cOut[g]), 32'(expC[cyc]));
         checkOutput($sformatf("frame_err[%0d]", g), 32'(eOut[g]), 32'(expE[cyc]));
         checkOutput($sformatf("addr[%0d]", g), 32'(aOut[g]), 32'(ea));
         obsD[g] = dOut[g];
         obsV[g] = vOut[g];
         obsC[g] = cOut[g];
         obsE[g] = eOut[g];
         obsA[g] = aOut[g];
      end
      if (ctrl) begin
         if (filling && fillQ.size() > 0) begin
`ifdef DATA_UNFIFO_FRAME_ERR_EN
            expE[cyc + 1] = 1'b1;
`endif
         end
         fillQ.delete();
         filling = 1'b1;
      end
      if (filling) begin
         fillQ.push_back(data);
         if (fillQ.size() == 16) begin
            // Output position a carries frame word (a - offset) mod 16.
            for (int a = 0; a < 16; a++) begin
               expV[cyc + 2 + a] = 1'b1;
               expC[cyc + 2 + a] = (a == 0);
               for (int g = 0; g < NI; g++)
                  expD[g][cyc + 2 + a] = fillQ[((a - offOf(g)) % 16 + 16) % 16];
            end
            fillQ.delete();
            filling = 1'b0;
         end
      end
      cyc++;
   endtask

   // Assert reset mid-cycle, check that outputs clear at once, then release.
   task automatic doReset();
      @(negedge clk);
      rst    = 1'b0;
      ctrlIn = 1'b0;
      #1;
      for (int g = 0; g < NI; g++) begin
         checkOutput($sformatf("rst data_out[%0d]", g), dOut[g], 32'd0);
         checkOutput($sformatf("rst data_valid[%0d]", g), 32'(vOut[g]), 32'd0);
         checkOutput($sformatf("rst ctrl_out[%0d]", g), 32'(cOut[g]), 32'd0);
         checkOutput($sformatf("rst frame_err[%0d]", g), 32'(eOut[g]), 32'd0);
         checkOutput($sformatf("rst addr[%0d]", g), 32'(aOut[g]), 32'(offOf(g)));
         lastD[g] = 32'd0;
      end
      for (int c = cyc; c < NC; c++) begin
         expV[c] = 1'b0;
         expC[c] = 1'b0;
         expE[c] = 1'b0;
      end
      fillQ.delete();
      filling = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   // Safety net so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Main sequence: directed table, hand-written corners, then random.
   initial begin
      int seq[16] = '{13, 14, 15, 16, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
      logic [31:0] q [$];
      int t0, cntV, cntC, errCnt, errAt, rc, firstV;
      bit ctrl;

      nChecks = 0;
      nFail   = 0;
      cyc     = 0;
      filling = 1'b0;
      rst     = 1'b1;
      ctrlIn  = 1'b0;
      dataIn  = '0;
      for (int g = 0; g < NI; g++) lastD[g] = '0;

      // Single frame, offset 4, word k = k+1.
      for (int i = 0; i < 36; i++) begin
         tbl[i].ctrlIn   = (i == 0);
         tbl[i].dataIn   = (i < 16) ? 32'(i + 1) : 32'hDEAD_0000 + 32'(i);
         tbl[i].expValid = (i >= 17 && i <= 32);
         tbl[i].expCtrl  = (i == 17);
         tbl[i].expData  = (i < 17) ? 32'd0 : (i <= 32) ? 32'(seq[i - 17]) : 32'd12;
         tbl[i].expAddr  = (i < 16) ? 4'((i + 4) % 16) : 4'd4;
      end

      doReset();

      $display("[TB] table: single frame, WR_OFFSET=4");
      for (int i = 0; i < 36; i++) begin
         applyStimulus(tbl[i].ctrlIn, tbl[i].dataIn);
         checkOutput("tbl data_out", obsD[1], tbl[i].expData);
         checkOutput("tbl data_valid", 32'(obsV[1]), 32'(tbl[i].expValid));
         checkOutput("tbl ctrl_out", 32'(obsC[1]), 32'(tbl[i].expCtrl));
         checkOutput("tbl addr", 32'(obsA[1]), 32'(tbl[i].expAddr));
      end

      $display("[TB] WR_OFFSET=15 wrap, word k = k");
      q.delete();
      for (int i = 0; i < 40; i++) begin
         applyStimulus(i == 0, (i < 16) ? 32'(i) : 32'hFFFF_FFFF);
         if (obsV[4]) q.push_back(obsD[4]);
      end
      checkOutput("wrap count", 32'(q.size()), 32'd16);
      for (int a = 0; a < 16 && a < q.size(); a++)
         checkOutput("wrap order", q[a], 32'((a + 1) % 16));

      $display("[TB] four back-to-back frames");
      t0 = cyc; cntV = 0; cntC = 0;
      for (int i = 0; i < 84; i++) begin
         applyStimulus((i < 64) && (i % 16 == 0), (i < 64) ? 32'(500 + i) : 32'd0);
         if (obsV[0]) begin
            if ((cyc - 1 - t0) >= 17 && (cyc - 1 - t0) <= 80) cntV++;
            else cntV += 1000;
         end
         if (obsC[0]) cntC++;
      end
      checkOutput("b2b valid run", 32'(cntV), 32'd64);
      checkOutput("b2b ctrl_out count", 32'(cntC), 32'd4);

      $display("[TB] restart at wr_cnt=7, WR_OFFSET=0");
      q.delete(); errCnt = 0; errAt = -1; rc = -1;
      for (int i = 0; i < 45; i++) begin
         if (i < 7) applyStimulus(i == 0, 32'(900 + i));
         else if (i < 23) begin
            if (i == 7) rc = cyc;
            applyStimulus(i == 7, 32'(101 + i - 7));
         end else applyStimulus(1'b0, 32'd0);
         if (obsV[0]) q.push_back(obsD[0]);
         if (obsE[0]) begin errCnt++; errAt = cyc - 1; end
      end
`ifdef DATA_UNFIFO_FRAME_ERR_EN
      checkOutput("restart err count", 32'(errCnt), 32'd1);
      checkOutput("restart err cycle", 32'(errAt), 32'(rc + 1));
`else
      checkOutput("restart err count", 32'(errCnt), 32'd0);
`endif
      checkOutput("restart out count", 32'(q.size()), 32'd16);
      for (int a = 0; a < 16 && a < q.size(); a++)
         checkOutput("restart out word", q[a], 32'(101 + a));

      $display("[TB] reset at wr_cnt=9 with a frame draining");
      for (int i = 0; i < 25; i++)
         applyStimulus((i == 0) || (i == 16), (i < 16) ? 32'(200 + i) : 32'(300 + i - 16));
      doReset();
      q.delete(); t0 = cyc; firstV = -1;
      for (int i = 0; i < 40; i++) begin
         applyStimulus(i == 0, (i < 16) ? 32'(400 + i) : 32'd0);
         if (obsV[0]) begin
            q.push_back(obsD[0]);
            if (firstV < 0) firstV = cyc - 1 - t0;
         end
      end
      checkOutput("post-reset first valid", 32'(firstV), 32'd17);
      checkOutput("post-reset out count", 32'(q.size()), 32'd16);
      for (int a = 0; a < 16 && a < q.size(); a++)
         checkOutput("post-reset out word", q[a], 32'(400 + a));

      $display("[TB] randomized frames with restarts");
      for (int i = 0; i < 1200; i++) begin
         if (filling && fillQ.size() == 15) ctrl = 1'b0;
         else if (!filling) ctrl = ($urandom_range(0, 3) == 0);
         else ctrl = ($urandom_range(0, 39) == 0);
         applyStimulus(ctrl, $urandom);
      end
      for (int i = 0; i < 40; i++) applyStimulus(1'b0, $urandom);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule

// File: doc/data_unfifo_blk.md
# data_unfifo_blk

Single-lane inverse-reorder buffer for the 64-point FFT datapath. It accepts one 16-word frame, marked by a `ctrl_in` pulse on word 0, and writes word k to address (k + WR_OFFSET) mod 16. Once the frame is complete, it reads the frame back linearly from address 0 to 15. Four instances with WR_OFFSET = 0, 4, 8 and 12 undo the lane-staggered read ordering applied upstream, restoring natural order before the next butterfly stage. Ping-pong banking sustains back-to-back frames with no gap cycles.

## Interface
- WIDTH, 32, data word width in bits
- WR_OFFSET, 0, write-address rotation; legal range 0..15

- clk  in  1  clock; all logic on posedge
- rst  in  1  asynchronous, active-low reset
- data_in  in  WIDTH  input word; sampled every cycle while a frame is filling
- ctrl_in  in  1  high for exactly one cycle, coincident with word 0 of a frame
- data_out  out  WIDTH  registered output word
- ctrl_out  out  1  high for one cycle, coincident with output word at read address 0
- data_valid  out  1  high for the 16 cycles that carry a frame on data_out
- addr  out  4  write address used this cycle, (wr_cnt + WR_OFFSET) mod 16
- frame_err  out  1  one-cycle pulse on a restarted partial frame (see Configuration)

## Operation
- Storage: 2 banks × 16 × WIDTH, plus a write-bank select `wb` and a read-bank select `rb`.
- Write FSM states:
  - W_IDLE to W_FILL on `ctrl_in`; word 0 is written in that same cycle with wr_cnt=0.
  - In W_FILL, wr_cnt increments each cycle.
  - When wr_cnt=15, the write completes, `wb` toggles, a "bank ready" event is raised for the read FSM, and the state returns to W_IDLE.
  - If `ctrl_in` is also high in that cycle, the block goes straight to W_FILL with wr_cnt=0 in the new bank (back-to-back frames).
- Restart: `ctrl_in` while in W_FILL with wr_cnt≠0 discards the partial frame. wr_cnt resets to 0, the current word is written as word 0 to the same bank, and no bank-ready event is raised.
- Write address: (wr_cnt + WR_OFFSET) mod 16, 4-bit wrap-around.
- Read FSM states:
  - R_IDLE to R_RUN on bank ready; `rb` latches the bank just filled and rd_cnt=0.
  - In R_RUN, rd_cnt increments 0..15.
  - After rd_cnt=15, the state returns to R_IDLE, or restarts at 0 if a new bank-ready event occurs in the same cycle.
- Output: data_out <= bank[rb][rd_cnt], registered.
  - data_valid and ctrl_out are delayed one cycle to align with data_out.
  - ctrl_out is asserted for rd_cnt=0.
- data_out holds its last value when data_valid=0.
- addr outputs the write address every cycle, including idle cycles (wr_cnt held at 0 when idle).
- Overrun is impossible: a fill takes 16 cycles and a read takes 16 cycles, so the read of bank N always finishes before bank N is rewritten.

## Timing
- Reset values (rst=0, asynchronous): data_out=0, ctrl_out=0, data_valid=0, frame_err=0, addr=WR_OFFSET. Both FSMs go to idle, wb=0, rb=0, and all counters are 0. Memory contents are not reset.
- Latency:
  - `ctrl_in` at cycle T (word 0) means word 15 is written at T+15.
  - Read of address 0 occurs at T+16.
  - data_out, ctrl_out and data_valid are first valid at T+17.
  - data_valid stays high through T+32.
- Back-to-back frames: with `ctrl_in` at T and T+16, data_valid stays high continuously from T+17 to T+48.
- Reset asserted mid-frame aborts both FSMs immediately. The first frame after release needs a fresh `ctrl_in`.

## Configuration
- DATA_UNFIFO_FRAME_ERR_EN defined: a restart pulses frame_err for one cycle, in the cycle after the restarting `ctrl_in`.
- DATA_UNFIFO_FRAME_ERR_EN undefined: the frame_err port remains, tied to 0, and no detection logic is built. Restart behaviour itself is unchanged.

## Test plan
- Single frame, WR_OFFSET=4, word k = k+1 (k=0..15), `ctrl_in` at T -> ctrl_out at T+17; data_out sequence 13,14,15,16,1,2,…,12; data_valid high T+17..T+32.
- Four instances with WR_OFFSET 0/4/8/12, back-to-back frames at T, T+16, T+32, T+48 -> data_valid high continuously T+17..T+80; each frame's rotated order matches its offset; addr runs 0..15, 4..3, 8..7, 12..11 per frame.
- Restart at wr_cnt=7, then a full frame of values 101..116, WR_OFFSET=0 -> frame_err pulse one cycle after the restart (macro defined); only 101..116 are output, in order; no output is produced for the partial frame.
- Reset asserted at wr_cnt=9 and released, then a new frame -> all outputs return to reset values immediately; the new frame is output correctly at +17; no stale frame appears.
- WR_OFFSET=15 wrap-around, word k = k -> output order 1,2,…,15,0.
- Build without DATA_UNFIFO_FRAME_ERR_EN and repeat the restart scenario -> frame_err stays 0; data output is identical to the macro-defined case.
